// File: rtl/pbus_pkg.sv
// pbus_pkg: shared types and constants for the 0xC00000 peripheral-page fabric.
// Used by pbus_fabric (optional error log enabled by PBUS_ERRLOG_EN).
package pbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } pbus_state_e;

  localparam int unsigned DEF_NSLOT   = 8;
  localparam int unsigned DEF_SLOT_AW = 3;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned TO_CNT_W    = 8;

  // Width of a slot index; never below 1 so the select stays a legal vector.
  function automatic int unsigned slot_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbus_fabric_if.sv
// pbus_fabric_if: Wishbone-classic slave side plus peripheral slot bus.
// slave modport is the fabric's view; master modport is the core/peripheral side.
interface pbus_fabric_if
  import pbus_pkg::*;
#(
  parameter int unsigned NSLOT   = DEF_NSLOT,
  parameter int unsigned SLOT_AW = DEF_SLOT_AW,
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 8
) ();

  logic [AW-1:0]       wb_adr_i;
  logic [DW-1:0]       wb_dat_i;
  logic [DW-1:0]       wb_dat_o;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic [NSLOT-1:0]    p_stb_o;
  logic                p_we_o;
  logic [SLOT_AW-1:0]  p_adr_o;
  logic [DW-1:0]       p_dat_o;
  logic [NSLOT*DW-1:0] p_dat_i;
  logic [NSLOT-1:0]    p_ack_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, p_dat_i, p_ack_i,
    output wb_dat_o, wb_ack_o, wb_err_o, p_stb_o, p_we_o, p_adr_o, p_dat_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, p_dat_i, p_ack_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, p_stb_o, p_we_o, p_adr_o, p_dat_o
  );

endinterface

// File: rtl/pbus_slot_dec.sv
// pbus_slot_dec: combinational page-address decode into slot index, range flag
// and one-hot slot select. Only the bits above the register index are presented.
module pbus_slot_dec
  import pbus_pkg::*;
#(
  parameter int unsigned AW      = 11,
  parameter int unsigned SLOT_AW = DEF_SLOT_AW,
  parameter int unsigned NSLOT   = DEF_NSLOT
) (
  input  logic [AW-1:SLOT_AW]             adr,
  output logic [slot_idx_w(NSLOT)-1:0]    slot,
  output logic                            in_range,
  output logic [NSLOT-1:0]                onehot
);

  localparam int unsigned SW = slot_idx_w(NSLOT);

  // Slot index and its one-hot select.
  always_comb begin
    slot         = adr[SLOT_AW +: SW];
    onehot       = '0;
    onehot[slot] = 1'b1;
  end

  generate
    if (AW > SLOT_AW + SW) begin : g_range
      // Anything above the slot field must be zero to hit a peripheral.
      always_comb in_range = ~|adr[AW-1:SLOT_AW+SW];
    end else begin : g_full
      // Page holds exactly NSLOT slots, so every address decodes.
      always_comb in_range = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/pbus_fabric.sv
// pbus_fabric: N-slot Wishbone-classic peripheral fabric with registered read
// mux, fixed/ack-mode wait states, timeout and out-of-range bus errors.
// Optional error log (err_adr_o/err_cnt_o/err_clr_i) under `PBUS_ERRLOG_EN.
module pbus_fabric
  import pbus_pkg::*;
#(
  parameter int unsigned      NSLOT    = DEF_NSLOT,
  parameter int unsigned      SLOT_AW  = DEF_SLOT_AW,
  parameter int unsigned      AW       = 11,
  parameter int unsigned      DW       = 8,
  parameter logic [NSLOT-1:0] ACK_MASK = '0,
  parameter int unsigned      TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  pbus_fabric_if.slave         bus
`ifdef PBUS_ERRLOG_EN
  ,
  output logic [AW-1:0]        err_adr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
`endif
);

  localparam int unsigned SW = slot_idx_w(NSLOT);

  pbus_state_e         state_q, state_d;
  logic [SW-1:0]       slot_q;
  logic [SW-1:0]       dec_slot;
  logic                dec_in_range;
  logic [NSLOT-1:0]    dec_onehot;
  logic [TO_CNT_W-1:0] cnt_q;
  logic [DW-1:0]       rd_slice;
  logic                latch, start_acc, fin_ok, fin_err, abort, cnt_inc;

  pbus_slot_dec #(
    .AW      (AW),
    .SLOT_AW (SLOT_AW),
    .NSLOT   (NSLOT)
  ) u_dec (
    .adr      (bus.wb_adr_i[AW-1:SLOT_AW]),
    .slot     (dec_slot),
    .in_range (dec_in_range),
    .onehot   (dec_onehot)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle transfer events; abort outranks any slot ack.
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    start_acc = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    abort     = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          latch = 1'b1;
          if (dec_in_range) begin
            start_acc = 1'b1;
            state_d   = ACCESS;
          end else begin
            fin_err = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (!bus.wb_cyc_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (!ACK_MASK[slot_q] || bus.p_ack_i[slot_q]) begin
          fin_ok  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          fin_err = 1'b1;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-data slice of the currently latched slot.
  always_comb begin
    rd_slice = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (slot_q == SW'(k)) rd_slice = bus.p_dat_i[k*DW +: DW];
    end
  end

  // Latched request, slot strobe, timeout counter and WB response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      cnt_q        <= '0;
      bus.p_stb_o  <= '0;
      bus.p_we_o   <= 1'b0;
      bus.p_adr_o  <= '0;
      bus.p_dat_o  <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
    end else begin
      bus.wb_ack_o <= fin_ok;
      bus.wb_err_o <= fin_err;
      if (latch) begin
        slot_q      <= dec_slot;
        bus.p_we_o  <= bus.wb_we_i;
        bus.p_adr_o <= bus.wb_adr_i[SLOT_AW-1:0];
        bus.p_dat_o <= bus.wb_dat_i;
        bus.p_stb_o <= start_acc ? dec_onehot : '0;
      end
      if (fin_ok || fin_err || abort) bus.p_stb_o <= '0;
      // Latched request fields are zeroed on the way back to IDLE.
      if (state_q == RESP || abort) begin
        bus.p_we_o  <= 1'b0;
        bus.p_adr_o <= '0;
        bus.p_dat_o <= '0;
      end
      if (cnt_inc)                         cnt_q <= cnt_q + TO_CNT_W'(1);
      else if (fin_ok || fin_err || abort) cnt_q <= '0;
      if (fin_ok && !bus.p_we_o)  bus.wb_dat_o <= rd_slice;
      else if (fin_ok || fin_err) bus.wb_dat_o <= '0;
    end
  end

`ifdef PBUS_ERRLOG_EN
  logic [AW-1:0] adr_q;
  logic [AW-1:0] err_adr_src;

  // Out-of-range errors fire in the latch cycle, before adr_q is loaded.
  always_comb err_adr_src = latch ? bus.wb_adr_i : adr_q;

  // Error address capture and saturating error count; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q     <= '0;
      err_adr_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (latch)   adr_q     <= bus.wb_adr_i;
      if (fin_err) err_adr_o <= err_adr_src;
      if (err_clr_i)                     err_cnt_o <= '0;
      else if (fin_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pbus_fabric.sv
// tb_pbus_fabric: directed self-checking bench for pbus_fabric
// (NSLOT=8, SLOT_AW=3, ACK_MASK=8'h02, TIMEOUT=15); error-log checks under PBUS_ERRLOG_EN.
module tb_pbus_fabric;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pbus_fabric_if #(.NSLOT(8), .SLOT_AW(3), .AW(11), .DW(8)) bus ();

`ifdef PBUS_ERRLOG_EN
  logic [10:0] err_adr;
  logic [7:0]  err_cnt;
  logic        err_clr = 1'b0;
`endif

  pbus_fabric #(
    .NSLOT    (8),
    .SLOT_AW  (3),
    .AW       (11),
    .DW       (8),
    .ACK_MASK (8'h02),
    .TIMEOUT  (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PBUS_ERRLOG_EN
    ,
    .err_adr_o (err_adr),
    .err_cnt_o (err_cnt),
    .err_clr_i (err_clr)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [10:0] adr, input logic we, input logic [7:0] dat);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
  endtask

  task automatic drop();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic set_slot(input int k, input logic [7:0] v);
    bus.p_dat_i[k*8 +: 8] = v;
  endtask

  task automatic fixed_read(input string tag, input logic [10:0] adr,
                            input logic [7:0] exp_stb, input logic [7:0] exp_dat);
    req(adr, 1'b0, 8'h00);
    tick();
    check_eq({tag, "_stb"}, bus.p_stb_o, exp_stb);
    check_eq({tag, "_ack_early"}, bus.wb_ack_o, 0);
    tick();
    check_eq({tag, "_ack"}, bus.wb_ack_o, 1);
    check_eq({tag, "_err"}, bus.wb_err_o, 0);
    check_eq({tag, "_dat"}, bus.wb_dat_o, exp_dat);
    check_eq({tag, "_stb_off"}, bus.p_stb_o, 0);
    drop();
    tick();
    check_eq({tag, "_ack_once"}, bus.wb_ack_o, 0);
  endtask

  // Invariants checked on every falling edge whenever they can be violated.
  always @(negedge clk) begin
    if (bus.wb_ack_o || bus.wb_err_o) check_eq("ack_err_excl", bus.wb_ack_o & bus.wb_err_o, 0);
    if (bus.p_stb_o != '0)            check_eq("stb_onehot", $onehot(bus.p_stb_o), 1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.p_dat_i  = '0;
    bus.p_ack_i  = '0;
    set_slot(0, 8'h42);
    set_slot(1, 8'h5A);
    set_slot(2, 8'hA5);
    set_slot(3, 8'h77);
    set_slot(4, 8'h99);

    // Reset state
    tick();
    tick();
    check_eq("rst_stb", bus.p_stb_o, 0);
    check_eq("rst_we", bus.p_we_o, 0);
    check_eq("rst_padr", bus.p_adr_o, 0);
    check_eq("rst_pdat", bus.p_dat_o, 0);
    check_eq("rst_dat", bus.wb_dat_o, 0);
    check_eq("rst_ack", bus.wb_ack_o, 0);
    check_eq("rst_err", bus.wb_err_o, 0);
`ifdef PBUS_ERRLOG_EN
    check_eq("rst_errcnt", err_cnt, 0);
    check_eq("rst_erradr", err_adr, 0);
`endif
    rst = 1'b0;
    tick();

    // Fixed-slot read 0x012 -> slot 2 reg 2
    req(11'h012, 1'b0, 8'h00);
    tick();
    check_eq("rd1_padr", bus.p_adr_o, 2);
    check_eq("rd1_pwe", bus.p_we_o, 0);
    drop();
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    check_eq("rd1_stb", bus.p_stb_o, 8'h04);
    tick();
    check_eq("rd1_ack", bus.wb_ack_o, 1);
    check_eq("rd1_dat", bus.wb_dat_o, 8'hA5);
    check_eq("rd1_stb_off", bus.p_stb_o, 0);
    drop();
    tick();
    check_eq("rd1_ack_once", bus.wb_ack_o, 0);

    // Out-of-range read 0x040: error one cycle after the strobe is sampled
    req(11'h040, 1'b0, 8'h00);
    tick();
    check_eq("oor_err", bus.wb_err_o, 1);
    check_eq("oor_ack", bus.wb_ack_o, 0);
    check_eq("oor_stb", bus.p_stb_o, 0);
    check_eq("oor_dat", bus.wb_dat_o, 0);
`ifdef PBUS_ERRLOG_EN
    check_eq("oor_errcnt", err_cnt, 1);
    check_eq("oor_erradr", err_adr, 11'h040);
`endif
    drop();
    tick();
    check_eq("oor_err_once", bus.wb_err_o, 0);

    // Back-to-back reads: request held through RESP starts the next one
    req(11'h018, 1'b0, 8'h00);
    tick();
    check_eq("b2b_stb0", bus.p_stb_o, 8'h08);
    tick();
    check_eq("b2b_ack0", bus.wb_ack_o, 1);
    check_eq("b2b_dat0", bus.wb_dat_o, 8'h77);
    bus.wb_adr_i = 11'h021;
    tick();
    check_eq("b2b_gap_ack", bus.wb_ack_o, 0);
    check_eq("b2b_gap_stb", bus.p_stb_o, 0);
    tick();
    check_eq("b2b_stb1", bus.p_stb_o, 8'h10);
    check_eq("b2b_padr1", bus.p_adr_o, 1);
    tick();
    check_eq("b2b_ack1", bus.wb_ack_o, 1);
    check_eq("b2b_dat1", bus.wb_dat_o, 8'h99);
    drop();
    tick();

    // Ack-mode slot 1 without ack: timeout after 15 ACCESS cycles
    req(11'h00B, 1'b0, 8'h00);
    tick();
    for (int i = 1; i <= 15; i++) begin
      check_eq($sformatf("to_stb_c%0d", i), bus.p_stb_o, 8'h02);
      check_eq($sformatf("to_noerr_c%0d", i), bus.wb_err_o, 0);
      tick();
    end
    check_eq("to_err", bus.wb_err_o, 1);
    check_eq("to_ack", bus.wb_ack_o, 0);
    check_eq("to_stb_off", bus.p_stb_o, 0);
    check_eq("to_dat", bus.wb_dat_o, 0);
`ifdef PBUS_ERRLOG_EN
    check_eq("to_errcnt", err_cnt, 2);
    check_eq("to_erradr", err_adr, 11'h00B);
`endif
    drop();
    tick();
    check_eq("to_err_once", bus.wb_err_o, 0);

    // Ack-mode write 0x3C to 0x00B; stray acks on other slots are ignored
    req(11'h00B, 1'b1, 8'h3C);
    tick();
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("wr_stb_c%0d", i), bus.p_stb_o, 8'h02);
      check_eq($sformatf("wr_we_c%0d", i), bus.p_we_o, 1);
      check_eq($sformatf("wr_padr_c%0d", i), bus.p_adr_o, 3);
      check_eq($sformatf("wr_pdat_c%0d", i), bus.p_dat_o, 8'h3C);
      check_eq($sformatf("wr_noack_c%0d", i), bus.wb_ack_o, 0);
      bus.p_ack_i = (i == 4) ? 8'h02 : 8'h0D;
      tick();
    end
    bus.p_ack_i = '0;
    check_eq("wr_ack", bus.wb_ack_o, 1);
    check_eq("wr_err", bus.wb_err_o, 0);
    check_eq("wr_dat", bus.wb_dat_o, 0);
    check_eq("wr_stb_off", bus.p_stb_o, 0);
    drop();
    tick();
    check_eq("wr_ack_once", bus.wb_ack_o, 0);

    fixed_read("rd0", 11'h005, 8'h01, 8'h42);

    // Abort: cyc drops mid-ACCESS, coincident slot ack must not complete it
    set_slot(1, 8'hEE);
    req(11'h009, 1'b0, 8'h00);
    tick();
    check_eq("ab_stb", bus.p_stb_o, 8'h02);
    check_eq("ab_padr", bus.p_adr_o, 1);
    tick();
    bus.wb_cyc_i = 1'b0;
    bus.p_ack_i  = 8'h02;
    tick();
    check_eq("ab_stb_off", bus.p_stb_o, 0);
    check_eq("ab_ack", bus.wb_ack_o, 0);
    check_eq("ab_err", bus.wb_err_o, 0);
    check_eq("ab_padr_off", bus.p_adr_o, 0);
    check_eq("ab_dat_held", bus.wb_dat_o, 8'h42);
    tick();
    check_eq("ab_ack_late", bus.wb_ack_o, 0);
    check_eq("ab_err_late", bus.wb_err_o, 0);
`ifdef PBUS_ERRLOG_EN
    check_eq("ab_errcnt", err_cnt, 2);
`endif
    drop();
    bus.p_ack_i = '0;
    set_slot(2, 8'hC3);
    fixed_read("post_ab", 11'h012, 8'h04, 8'hC3);

    // Asynchronous reset mid-ACCESS
    req(11'h00A, 1'b1, 8'h81);
    tick();
    check_eq("rsta_stb", bus.p_stb_o, 8'h02);
    check_eq("rsta_pdat", bus.p_dat_o, 8'h81);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rsta_stb_off", bus.p_stb_o, 0);
    check_eq("rsta_we", bus.p_we_o, 0);
    check_eq("rsta_padr", bus.p_adr_o, 0);
    check_eq("rsta_pdat_off", bus.p_dat_o, 0);
    check_eq("rsta_dat", bus.wb_dat_o, 0);
    check_eq("rsta_ack", bus.wb_ack_o, 0);
    check_eq("rsta_err", bus.wb_err_o, 0);
`ifdef PBUS_ERRLOG_EN
    check_eq("rsta_errcnt", err_cnt, 0);
    check_eq("rsta_erradr", err_adr, 0);
`endif
    drop();
    tick();
    rst = 1'b0;
    tick();
    set_slot(2, 8'h3D);
    fixed_read("post_rst", 11'h012, 8'h04, 8'h3D);

`ifdef PBUS_ERRLOG_EN
    // 300 forced timeouts saturate the count at 8'hFF
    for (int n = 0; n < 300; n++) begin
      req(11'h00B, 1'b0, 8'h00);
      repeat (16) tick();
      drop();
      tick();
    end
    check_eq("sat_errcnt", err_cnt, 8'hFF);
    check_eq("sat_erradr", err_adr, 11'h00B);
    // Clear coincident with an out-of-range error: clear wins, address still logged
    req(11'h7FF, 1'b0, 8'h00);
    err_clr = 1'b1;
    tick();
    check_eq("clr_err", bus.wb_err_o, 1);
    check_eq("clr_errcnt", err_cnt, 0);
    check_eq("clr_erradr", err_adr, 11'h7FF);
    err_clr = 1'b0;
    drop();
    tick();
    check_eq("clr_errcnt_hold", err_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pbus_fabric.md
Name: pbus_fabric

Overview:
- Parametrised Wishbone-classic slave fabric for the 0xC00000 peripheral page.
- Replaces hand-wired per-peripheral strobes with a generic N-slot decoder, a registered read mux, ack/wait-state generation and a bus-error path (out-of-range address or slave timeout).
- Sits between the core's WB master and the peripherals: SPI, GPIO, timer, interrupt controller and future slots.

Parameters:
- NSLOT, 8, number of peripheral slots (power of two, 2..16).
- SLOT_AW, 3, register address bits per slot (2^SLOT_AW regs per slot).
- AW, 11, WB address width.
- DW, 8, data width.
- ACK_MASK, 8'h00, per-slot bit. 1 = wait for p_ack_i. 0 = fixed single-cycle access.
- TIMEOUT, 15, maximum ACCESS cycles for ack-mode slots before error (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wb_adr_i  in  AW  byte address within page
- wb_dat_i  in  DW  write data
- wb_dat_o  out  DW  registered read data
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  transfer done
- wb_err_o  out  1  transfer error
- p_stb_o  out  NSLOT  one-hot slot strobe
- p_we_o  out  1  latched write enable
- p_adr_o  out  SLOT_AW  latched register index
- p_dat_o  out  DW  latched write data
- p_dat_i  in  NSLOT*DW  slot read data; slot k occupies bits [k*DW +: DW]
- p_ack_i  in  NSLOT  slot ack (used only where ACK_MASK bit set)
- err_adr_o  out  AW  (PBUS_ERRLOG_EN only) address of last errored transfer
- err_cnt_o  out  8  (PBUS_ERRLOG_EN only) saturating error count
- err_clr_i  in  1  (PBUS_ERRLOG_EN only) clears err_cnt_o

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: p_stb_o, p_we_o, p_adr_o, p_dat_o, wb_dat_o, wb_ack_o, wb_err_o, timeout counter, err_adr_o, err_cnt_o.
- Decode: slot = adr[SLOT_AW +: log2(NSLOT)]. In range iff adr[AW-1 : SLOT_AW+log2(NSLOT)] == 0.
- FSM:
  - IDLE: on wb_cyc_i & wb_stb_i, latch adr/we/dat and the slot. In range -> ACCESS. Out of range -> RESP with err flag.
  - ACCESS: p_stb_o[slot]=1, counter increments each cycle.
    - Fixed slot: after 1 cycle, capture p_dat_i slice into wb_dat_o (reads only) -> RESP ok.
    - Ack slot: on p_ack_i[slot]=1, capture data -> RESP ok. Counter reaching TIMEOUT with no ack -> RESP err.
  - RESP: exactly one of wb_ack_o / wb_err_o high for exactly 1 cycle -> IDLE.
- Latency, fixed slot: stb sampled in cycle n -> ACCESS in n+1 -> ack visible in n+2.
- Latency, ack slot: ack visible 1 cycle after the cycle p_ack_i is sampled.
- Read data: wb_dat_o holds captured data until the next capture. Writes and errors drive wb_dat_o = 0 in RESP.
- Abort: wb_cyc_i falling during ACCESS -> p_stb_o cleared next edge, return to IDLE, no ack/err, no data capture, no error logged.
- p_ack_i on a non-selected slot or in IDLE/RESP is ignored. ack and err are never asserted together.
- p_stb_o is never multi-hot. p_we_o/p_adr_o/p_dat_o are stable for the whole ACCESS.
- Back-to-back: a request present in the cycle after RESP starts a new transfer. No combinational path from wb_* inputs to wb_ack_o.

Optional Feature:
- Macro: PBUS_ERRLOG_EN.
- Defined:
  - Every wb_err_o pulse loads err_adr_o with the latched address.
  - err_cnt_o increments, saturating at 8'hFF.
  - err_clr_i zeroes the count; clear wins over a simultaneous increment. err_adr_o is not cleared.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pbus_pkg:
  - FSM state enum {IDLE, ACCESS, RESP}.
  - Slot index width function (clog2).
  - Default NSLOT/SLOT_AW constants.
  - Err-counter width.
- Sub-module pbus_slot_dec: combinational address -> {slot index, in_range, one-hot}, parametrised by AW/SLOT_AW/NSLOT.

Test Plan (NSLOT=8, SLOT_AW=3, ACK_MASK=8'h02, TIMEOUT=15):
- Read 0x012 (slot 2, reg 2), p_dat_i slot2 = 8'hA5 -> p_stb_o=8'h04 for 1 cycle; wb_ack_o 2 cycles after stb sampled; wb_dat_o=8'hA5.
- Write 8'h3C to 0x00B (slot 1, ack mode), p_ack_i[1] raised 4 cycles into ACCESS -> p_we_o=1, p_adr_o=3, p_dat_o=8'h3C held throughout; single wb_ack_o 1 cycle later.
- Access slot 1 with p_ack_i never raised -> wb_err_o after 15 ACCESS cycles, p_stb_o drops. With PBUS_ERRLOG_EN: err_cnt_o=1, err_adr_o=0x00B.
- Read 0x040 (out of range) -> wb_err_o 1 cycle after stb sampled, p_stb_o stays 0, wb_dat_o=0.
- Drop wb_cyc_i mid-ACCESS on slot 1; assert rst mid-ACCESS in a separate run -> no ack/err; all outputs return to 0; next transfer completes normally.
- 300 forced timeouts with PBUS_ERRLOG_EN, then err_clr_i coincident with another error -> err_cnt_o saturates at 8'hFF, then reads 0.
